// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter/sequencer sharing one UART_TX among NUM_REQ word producers.
// Optional TX_BUSY-rise timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_tx_busy,
  output logic [DATA_WIDTH-1:0]         o_tx_p_data,
  output logic                          o_tx_data_valid,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_active,
  output logic [15:0]                   o_frame_cnt,
  output logic                          o_tx_err
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [IDW-1:0]        r_rr_ptr;
  logic [IDW-1:0]        w_sel_idx;
  logic [IDW-1:0]        w_ptr_next;
  logic [IDW:0]          w_cand_raw;
  logic [IDW:0]          w_cand;
  logic                  w_hit;
  logic                  w_sel_found;
  logic                  w_grant;
  logic                  w_frame_done;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] r_tx_p_data;
  logic                  r_tx_data_valid;
  logic [IDW-1:0]        r_grant_id;
  logic [15:0]           r_frame_cnt;
  logic                  r_tx_err;

  // Round-robin search: the first valid requester at or after r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_cand_raw  = '0;
    w_cand      = '0;
    w_hit       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand_raw  = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      w_cand      = (w_cand_raw >= (IDW+1)'(NUM_REQ)) ? (w_cand_raw - (IDW+1)'(NUM_REQ)) : w_cand_raw;
      w_hit       = !w_sel_found && i_req_valid[w_cand[IDW-1:0]];
      w_sel_idx   = w_hit ? w_cand[IDW-1:0] : w_sel_idx;
      w_sel_found = w_sel_found | w_hit;
    end
  end

  assign w_grant      = (r_state == S_IDLE) && !i_rst && !i_tx_busy && w_sel_found;
  assign w_ptr_next   = (w_sel_idx == IDW'(NUM_REQ-1)) ? '0 : (w_sel_idx + IDW'(1));
  assign w_frame_done = (r_state == S_WAIT_DONE) && !i_tx_busy;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);

  logic [TOW-1:0] r_to_cnt;

  // Cycles spent in WAIT_BUSY; zero on every entry because it clears in all other states.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (r_state == S_WAIT_BUSY) begin
      r_to_cnt <= r_to_cnt + TOW'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == S_WAIT_BUSY) && !i_tx_busy && (r_to_cnt == TOW'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; Busy rising wins over a coincident timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_next = S_LAUNCH;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_LAUNCH: begin
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_state_next = S_WAIT_DONE;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Frame datapath: P_DATA and GRANT_ID hold from one accept to the next.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr        <= '0;
      r_tx_p_data     <= '0;
      r_tx_data_valid <= 1'b0;
      r_grant_id      <= '0;
      r_frame_cnt     <= 16'd0;
      r_tx_err        <= 1'b0;
    end else begin
      if (w_grant) begin
        r_tx_p_data <= i_req_data[w_sel_idx*DATA_WIDTH +: DATA_WIDTH];
        r_grant_id  <= w_sel_idx;
        r_rr_ptr    <= w_ptr_next;
      end else begin
        r_tx_p_data <= r_tx_p_data;
        r_grant_id  <= r_grant_id;
        r_rr_ptr    <= r_rr_ptr;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
      r_tx_data_valid <= w_grant;
      r_tx_err        <= w_timeout;
    end
  end

  // Output logic: ready is a combinational one-hot offered only in IDLE with the transmitter free.
  always_comb begin
    o_req_ready     = '0;
    o_active        = (r_state != S_IDLE);
    o_tx_p_data     = r_tx_p_data;
    o_tx_data_valid = r_tx_data_valid;
    o_grant_id      = r_grant_id;
    o_frame_cnt     = r_frame_cnt;
    o_tx_err        = r_tx_err;
    if (w_grant) begin
      o_req_ready = NUM_REQ'(1) << w_sel_idx;
    end else begin
      o_req_ready = '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level model plus per-cycle compare and
// directed scenarios; a small UART_TX stand-in raises Busy for FRAME_LEN cycles after each launch.
module tb_uart_tx_arbiter;

  localparam int N         = 4;
  localparam int DW        = 8;
  localparam int TO_CYC    = 16;
  localparam int FRAME_LEN = 6;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          tx_busy;
  logic [DW-1:0] tx_p_data;
  logic          tx_dv;
  logic [1:0]    grant_id;
  logic          active;
  logic [15:0]   frame_cnt;
  logic          tx_err;

  logic emu_busy;
  logic force_busy;
  logic emu_mute;

  assign tx_busy = emu_busy | force_busy;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .i_tx_busy(tx_busy), .o_tx_p_data(tx_p_data),
    .o_tx_data_valid(tx_dv), .o_grant_id(grant_id), .o_active(active),
    .o_frame_cnt(frame_cnt), .o_tx_err(tx_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;
  int dut_log[$];

  // Model: transaction view of the arbiter.
  logic        m_started = 1'b0;
  logic        m_in_frame;
  int          m_since;
  logic        m_busy_seen;
  int          m_ptr;
  logic [15:0] m_fc;
  logic [DW-1:0] m_data;
  int          m_grant;
  logic        m_err;
  int          m_accepts;
  int          m_log[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready_f();
    int p;
    p = pick(req_valid, m_ptr);
    if (m_in_frame || rst || tx_busy || p < 0) return '0;
    return N'(1) << p;
  endfunction

  // Model update on each rising edge, from the inputs that were stable across it.
  always @(posedge clk) begin
    if (rst) begin
      m_started   <= 1'b1;
      m_in_frame  <= 1'b0;
      m_since     <= 0;
      m_busy_seen <= 1'b0;
      m_ptr       <= 0;
      m_fc        <= 16'd0;
      m_data      <= '0;
      m_grant     <= 0;
      m_err       <= 1'b0;
      m_accepts   <= 0;
      m_log.delete();
    end else begin
      m_err <= 1'b0;
      if (!m_in_frame) begin
        if (!tx_busy && pick(req_valid, m_ptr) >= 0) begin
          m_in_frame  <= 1'b1;
          m_since     <= 1;
          m_busy_seen <= 1'b0;
          m_data      <= req_data[pick(req_valid, m_ptr)*DW +: DW];
          m_grant     <= pick(req_valid, m_ptr);
          m_ptr       <= (pick(req_valid, m_ptr) + 1) % N;
          m_accepts   <= m_accepts + 1;
          m_log.push_back(pick(req_valid, m_ptr));
        end
      end else begin
        m_since <= m_since + 1;
        if (m_since >= 2) begin
          if (!m_busy_seen) begin
            if (tx_busy) begin
              m_busy_seen <= 1'b1;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (m_since - 2 == TO_CYC - 1) begin
              m_in_frame <= 1'b0;
              m_err      <= 1'b1;
            end
`endif
          end else if (!tx_busy) begin
            m_in_frame <= 1'b0;
            m_fc       <= m_fc + 16'd1;
          end
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (m_started) begin
      chk("ready", req_ready, exp_ready_f());
      chk("active", active, m_in_frame);
      chk("data_valid", tx_dv, m_in_frame && (m_since == 1));
      chk("p_data", tx_p_data, m_data);
      chk("grant_id", grant_id, m_grant);
      chk("frame_cnt", frame_cnt, m_fc);
      chk("tx_err", tx_err, m_err);
      if (tx_dv === 1'b1) dut_log.push_back(int'(grant_id));
      if (tx_err === 1'b1) err_pulses++;
      if (rst) dut_log.delete();
    end
  end

  // UART_TX stand-in: Busy rises the edge after DATA_VALID, falls FRAME_LEN cycles later or on reset.
  initial begin
    emu_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_dv === 1'b1 && !emu_mute && !rst) begin
        @(posedge clk);
        #1 emu_busy = 1'b1;
        for (int k = 0; k < FRAME_LEN; k++) begin
          @(negedge clk);
          if (rst) break;
          @(posedge clk);
          #1;
        end
        #1 emu_busy = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_until_accepts(input string name, input int target);
    int n;
    n = 0;
    while (m_accepts < target && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_accept_bound"}, (m_accepts >= target), 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (active !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, active, 0);
  endtask

  initial begin
    int exp_t2[5];
    int exp_t3[3];
    int n;
    exp_t2 = '{0, 1, 2, 3, 0};
    exp_t3 = '{1, 0, 1};
    rst = 1'b1; req_valid = '0; req_data = '0; force_busy = 1'b0; emu_mute = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_active", active, 0);
    chk("rst_dv", tx_dv, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_pdata", tx_p_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word from requester 0.
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = 4'b0000;
    @(negedge clk);
    chk("t1_dv", tx_dv, 1);
    chk("t1_pdata", tx_p_data, 8'hA5);
    @(negedge clk);
    chk("t1_dv_one_cycle", tx_dv, 0);
    wait_idle("t1");
    chk("t1_frame_cnt", frame_cnt, 1);

    // All four continuously valid from a fresh pointer.
    do_reset();
    req_data = 32'h1312_1110;
    req_valid = 4'b1111;
    run_until_accepts("t2", 5);
    req_valid = 4'b0000;
    wait_idle("t2");
    chk("t2_frame_cnt", frame_cnt, 5);
    chk("t2_log_size", dut_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_grant_seq", (i < dut_log.size()) ? dut_log[i] : -1, exp_t2[i]);
      chk("t2_model_seq", (i < m_log.size()) ? m_log[i] : -1, exp_t2[i]);
    end

    // Move the pointer to 2, then requesters 0 and 1 together must wrap to 0 first.
    req_data = 32'h0000_2130;
    req_valid = 4'b0010;
    run_until_accepts("t3a", 6);
    req_valid = 4'b0000;
    wait_idle("t3a");
    req_data[15:0] = 16'h3130;
    req_valid = 4'b0011;
    run_until_accepts("t3b", 8);
    req_valid = 4'b0000;
    wait_idle("t3b");
    chk("t3_frame_cnt", frame_cnt, 8);
    chk("t3_pdata_last", tx_p_data, 8'h31);
    for (int i = 0; i < 3; i++) begin
      chk("t3_grant_seq", (5 + i < dut_log.size()) ? dut_log[5 + i] : -1, exp_t3[i]);
    end

    // Busy held high in IDLE blocks the grant.
    force_busy = 1'b1;
    req_data[7:0] = 8'h44;
    req_valid = 4'b0001;
    repeat (4) begin
      @(negedge clk);
      chk("t4_ready_blocked", req_ready, 0);
      chk("t4_active", active, 0);
    end
    @(posedge clk);
    #1 force_busy = 1'b0;
    @(negedge clk);
    chk("t4_ready_released", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = 4'b0000;
    wait_idle("t4");
    chk("t4_frame_cnt", frame_cnt, 9);
    chk("t4_pdata", tx_p_data, 8'h44);

    // Reset while the frame is on the wire.
    req_data[7:0] = 8'h55;
    req_valid = 4'b0001;
    run_until_accepts("t5", m_accepts + 1);
    req_valid = 4'b0000;
    n = 0;
    while (!(m_in_frame && m_busy_seen) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_reached_wait_done", (m_in_frame && m_busy_seen), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ready_in_rst", req_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_active", active, 0);
    chk("t5_frame_cnt", frame_cnt, 0);
    chk("t5_dv", tx_dv, 0);
    chk("t5_grant", grant_id, 0);
    chk("t5_pdata", tx_p_data, 0);
    chk("t5_err", tx_err, 0);

`ifdef UART_ARB_TIMEOUT_EN
    // Busy never rises: one error pulse, frame dropped.
    emu_mute = 1'b1;
    err_pulses = 0;
    req_data[7:0] = 8'h66;
    req_valid = 4'b0001;
    run_until_accepts("t6", m_accepts + 1);
    req_valid = 4'b0000;
    wait_idle("t6");
    @(negedge clk);
    chk("t6_err_pulses", err_pulses, 1);
    chk("t6_frame_cnt", frame_cnt, 0);
    emu_mute = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
